// File: rtl/uninasoc_pkg.sv
// Shared SoC constants and types: interrupt source count, claim ID type and gateway states.
package uninasoc_pkg;

    localparam int NUM_IRQ  = 3;
    localparam int IRQ_ID_W = $clog2(NUM_IRQ + 1);

    typedef logic [IRQ_ID_W-1:0] irq_id_t;

    typedef enum logic [1:0] {
        GW_IDLE,
        GW_PENDING,
        GW_CLAIMED
    } irq_gw_state_t;

endpackage

// File: rtl/uninasoc_irq_gateway.sv
// Per-source interrupt gateway: latches a level request, holds it through claim until completion.
// State updates on every edge; pending is a decode of the state flop.
module uninasoc_irq_gateway
    import uninasoc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic src,
    input  logic grant,
    input  logic complete,
    output logic pending
);

    irq_gw_state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            GW_IDLE:    if (src)      state_d = GW_PENDING;
            GW_PENDING: if (grant)    state_d = GW_CLAIMED;
            // Level is ignored here; a held request re-pends one edge after completion.
            GW_CLAIMED: if (complete) state_d = GW_IDLE;
            default:                  state_d = GW_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= GW_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign pending = (state_q == GW_PENDING);

endmodule

// File: rtl/uninasoc_irq_arbiter.sv
// Round-robin interrupt arbiter: gateways per source, enable masking, one core irq line, claim/complete.
// Claim response is registered one cycle after the request; gateway state moves on the request edge.
module uninasoc_irq_arbiter
    import uninasoc_pkg::*;
#(
    parameter int NUM_SRC = NUM_IRQ,
    parameter int ID_W    = $clog2(NUM_SRC + 1)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic [NUM_SRC-1:0] enable_i,
    output logic               irq_o,
    input  logic               claim_req_i,
    output logic               claim_ack_o,
    output logic [ID_W-1:0]    claim_id_o,
    input  logic               complete_valid_i,
    input  logic [ID_W-1:0]    complete_id_i
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] complete;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] hi_idx, lo_idx, win_idx;
    logic             hi_vld, lo_vld, win_vld;

    logic             claim_ack_q, claim_ack_d;
    logic [ID_W-1:0]  claim_id_q, claim_id_d;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
        // IDs outside 1..NUM_SRC match no gateway; a gateway not CLAIMED ignores the strobe.
        assign complete[g] = complete_valid_i && (complete_id_i == ID_W'(g + 1));

        uninasoc_irq_gateway u_gw (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .src      (irq_src_i[g]),
            .grant    (grant[g]),
            .complete (complete[g]),
            .pending  (pending[g])
        );
    end

    assign eligible = pending & enable_i;
    assign irq_o    = |eligible;

    // Two-pass search: lowest eligible above the pointer first, else lowest at or below it.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (eligible[i] && !hi_vld && (i > int'(rr_ptr_q))) begin
                hi_vld = 1'b1;
                hi_idx = PTR_W'(i);
            end
            if (eligible[i] && !lo_vld && (i <= int'(rr_ptr_q))) begin
                lo_vld = 1'b1;
                lo_idx = PTR_W'(i);
            end
        end
        win_vld = hi_vld | lo_vld;
        win_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        grant       = '0;
        rr_ptr_d    = rr_ptr_q;
        claim_ack_d = claim_req_i;
        claim_id_d  = claim_id_q;
        if (claim_req_i) begin
            claim_id_d = '0;
            if (win_vld) begin
                grant[win_idx] = 1'b1;
                rr_ptr_d       = win_idx;
                claim_id_d     = ID_W'(win_idx) + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q    <= PTR_W'(NUM_SRC - 1);
            claim_ack_q <= 1'b0;
            claim_id_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            claim_ack_q <= claim_ack_d;
            claim_id_q  <= claim_id_d;
        end
    end

    assign claim_ack_o = claim_ack_q;
    assign claim_id_o  = claim_id_q;

endmodule

// File: tb/tb_uninasoc_irq_arbiter.sv
// Scoreboard bench for the interrupt arbiter with a per-source state reference model.
module tb_uninasoc_irq_arbiter;

    localparam int N  = 3;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  irq_src = '0;
    logic [N-1:0]  enable = '0;
    logic          claim_req = 1'b0;
    logic          complete_valid = 1'b0;
    logic [IW-1:0] complete_id = '0;
    logic          irq_o;
    logic          claim_ack_o;
    logic [IW-1:0] claim_id_o;

    uninasoc_irq_arbiter #(.NUM_SRC(N), .ID_W(IW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .irq_src_i        (irq_src),
        .enable_i         (enable),
        .irq_o            (irq_o),
        .claim_req_i      (claim_req),
        .claim_ack_o      (claim_ack_o),
        .claim_id_o       (claim_id_o),
        .complete_valid_i (complete_valid),
        .complete_id_i    (complete_id)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: 0 = idle, 1 = pending, 2 = claimed.
    int st[N];
    int rr;
    int exp_q[$];
    int last_id;
    int mon_e;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < N; c++) st[c] = 0;
        rr = N - 1;
        exp_q.delete();
    endtask

    task automatic model_edge(input logic [N-1:0] s, input logic [N-1:0] e,
                              input logic c, input logic v, input int id);
        int old[N];
        int w;
        for (int k = 0; k < N; k++) old[k] = st[k];
        if (c) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (rr + k) % N;
                if (w < 0 && old[cand] == 1 && e[cand]) w = cand;
            end
            if (w >= 0) begin
                st[w] = 2;
                rr = w;
                last_id = w + 1;
            end else begin
                last_id = 0;
            end
            exp_q.push_back(last_id);
        end
        if (v && id >= 1 && id <= N && old[id-1] == 2) st[id-1] = 0;
        for (int k = 0; k < N; k++)
            if (old[k] == 0 && s[k]) st[k] = 1;
    endtask

    task automatic cyc(input logic [N-1:0] s, input logic [N-1:0] e,
                       input logic c, input logic v, input int id);
        int exp_irq;
        @(negedge clk);
        irq_src = s;
        enable = e;
        claim_req = c;
        complete_valid = v;
        complete_id = IW'(id);
        #1;
        exp_irq = 0;
        for (int k = 0; k < N; k++) if (st[k] == 1 && e[k]) exp_irq = 1;
        chk("irq_o", int'(irq_o), exp_irq);
        @(posedge clk);
        model_edge(s, e, c, v, id);
    endtask

    // Asserts reset asynchronously mid-cycle and releases it just after a rising edge.
    task automatic do_reset(input logic [N-1:0] s);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        irq_src = s;
        enable = '1;
        claim_req = 1'b0;
        complete_valid = 1'b0;
        complete_id = '0;
        #1;
        model_reset();
        chk("rst_irq", int'(irq_o), 0);
        chk("rst_ack", int'(claim_ack_o), 0);
        chk("rst_id", int'(claim_id_o), 0);
        repeat (2) @(negedge clk);
        chk("rst_hold_irq", int'(irq_o), 0);
        chk("rst_hold_ack", int'(claim_ack_o), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (claim_ack_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_ack", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("claim_id", int'(claim_id_o), mon_e);
                end
            end else if (exp_q.size() != 0) begin
                chk("missing_ack", 0, 1);
                exp_q.delete();
            end
        end
    end

    initial begin
        model_reset();
        last_id = 0;

        // Reset with sources high, then first edge pends everything.
        do_reset(3'b111);
        cyc(3'b111, 3'b111, 0, 0, 0);
        cyc(3'b111, 3'b111, 0, 0, 0);

        // Single source: claim, complete while still high, re-pend.
        do_reset(3'b000);
        cyc(3'b010, 3'b111, 0, 0, 0);
        cyc(3'b010, 3'b111, 1, 0, 0);
        cyc(3'b010, 3'b111, 0, 0, 0);
        cyc(3'b010, 3'b111, 0, 1, 2);
        cyc(3'b010, 3'b111, 0, 0, 0);
        cyc(3'b010, 3'b111, 0, 0, 0);

        // Round-robin with completion of each returned ID.
        do_reset(3'b000);
        cyc(3'b111, 3'b111, 0, 0, 0);
        for (int r = 0; r < 4; r++) begin
            cyc(3'b111, 3'b111, 1, 0, 0);
            cyc(3'b111, 3'b111, 0, 1, last_id);
            cyc(3'b111, 3'b111, 0, 0, 0);
        end

        // Back-to-back claims, fourth finds nothing.
        do_reset(3'b000);
        cyc(3'b111, 3'b111, 0, 0, 0);
        for (int r = 0; r < 4; r++) cyc(3'b111, 3'b111, 1, 0, 0);
        cyc(3'b111, 3'b111, 0, 0, 0);

        // Masking: disabled pending source, then enabled in the claim cycle.
        do_reset(3'b000);
        cyc(3'b100, 3'b011, 0, 0, 0);
        cyc(3'b100, 3'b011, 1, 0, 0);
        cyc(3'b100, 3'b111, 1, 0, 0);
        cyc(3'b000, 3'b111, 0, 0, 0);

        // Stray completions, then claim and complete together.
        do_reset(3'b000);
        cyc(3'b001, 3'b111, 0, 0, 0);
        cyc(3'b001, 3'b111, 1, 0, 0);
        cyc(3'b000, 3'b111, 0, 1, 0);
        cyc(3'b000, 3'b111, 0, 1, 5);
        cyc(3'b000, 3'b111, 0, 1, 2);
        cyc(3'b010, 3'b111, 0, 0, 0);
        cyc(3'b011, 3'b111, 1, 1, 1);
        cyc(3'b000, 3'b111, 0, 0, 0);
        cyc(3'b000, 3'b111, 1, 0, 0);

        // Randomized traffic with occasional mid-run reset.
        do_reset(3'b000);
        for (int t = 0; t < 400; t++) begin
            logic [N-1:0] s, e;
            logic c, v;
            int id;
            s = N'($urandom_range(0, 7));
            e = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : N'(3'b111);
            c = ($urandom_range(0, 2) == 0);
            v = ($urandom_range(0, 2) == 0);
            id = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : last_id;
            if (t == 200) do_reset(N'($urandom_range(0, 7)));
            cyc(s, e, c, v, id);
        end

        cyc(3'b000, 3'b111, 0, 0, 0);
        cyc(3'b000, 3'b111, 0, 0, 0);
        @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
